imem_fill: RTL and testbench
============================

# imem_fill

Line-fill engine between the L1 instruction cache and the 64-bit system memory port. On a cache miss (`b_rd` high) it latches the line-aligned miss address. It then fetches the line as `LINE_BITS/64` sequential single-beat reads and assembles them into one line register. It presents the completed line to the cache with a one-cycle `b_dv` pulse. It is the direct upstream supplier of the cache's `b_data`/`b_dv` refill port.

## Interface
- `LINE_BITS`, 256: cache line width in bits; multiple of 64, minimum 128.
- `TIMEOUT`, 255: cycles allowed per handshake wait before abort; only used with `IMEM_FILL_TIMEOUT_EN`.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous reset, active-low.
- `b_addr`  in  64  line-aligned miss address from cache.
- `b_rd`  in  1  miss request; level, held by cache until line installed.
- `b_data`  out  LINE_BITS  assembled line; beat k in bits [64k+63:64k].
- `b_dv`  out  1  line valid to cache, one cycle.
- `m_addr`  out  64  beat address to memory.
- `m_req`  out  1  beat read request.
- `m_gnt`  in  1  address accepted by memory.
- `m_data`  in  64  read data.
- `m_dv`  in  1  read data valid.
- `err`  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, REQ, WAIT, DONE. Beat counter `cnt` has width $clog2(LINE_BITS/64); latched address is `addr_q`.
- IDLE: on `b_rd`, `addr_q <= b_addr`, `cnt <= 0`, go to REQ. `m_dv`/`m_gnt` ignored.
- REQ: `m_req=1`, `m_addr = addr_q + 8*cnt`. On `m_gnt`, go to WAIT; otherwise stay with `m_req` and `m_addr` stable.
- WAIT: `m_req=0`. On `m_dv`, write `m_data` into beat slot `cnt`.
  - If `cnt` is the last beat, go to DONE.
  - Otherwise `cnt <= cnt+1` and go to REQ.
- DONE: `b_dv = b_rd && (b_addr == addr_q)`, combinational. Always go to IDLE next cycle.
- Stale fill: if the cache dropped `b_rd` or changed `b_addr` mid-fill (pipeline flush), the fill still completes on the bus. `b_dv` stays 0 in DONE and the line is discarded. A new miss is serviced from IDLE.
- `b_data` holds the last assembled line until overwritten beat-by-beat by the next fill.
- One outstanding memory transaction at most. The address never wraps within the line; beats are in ascending order.
- `m_dv` asserted in REQ, or in the same cycle as `m_gnt`, is a protocol violation and is ignored.

## Timing
- Reset values: `m_req=0`, `m_addr=0`, `b_dv=0`, `b_data=0`, `err=0`, state IDLE, `cnt=0`.
- Reset mid-fill abandons the fill immediately. Late `m_dv` after reset is ignored because the block is in IDLE.
- Zero-wait memory (`m_gnt` in the first REQ cycle, `m_dv` in the first WAIT cycle) costs 2 cycles per beat.
  - Miss seen in cycle 0 gives `b_dv` in cycle 1 + 2·(LINE_BITS/64).
  - For the default LINE_BITS=256, that is cycle 9.
- `b_dv` is high for exactly one cycle per completed matching fill. In the following cycle the cache hits and drops `b_rd`.
- Back-to-back misses: the earliest new IDLE acceptance is the cycle after DONE.

## Configuration
- `IMEM_FILL_TIMEOUT_EN` defined:
  - A wait counter resets on every state entry and increments each cycle in REQ or WAIT.
  - On reaching `TIMEOUT`, pulse `err` for one cycle, force `m_req=0`, and return to IDLE without `b_dv`.
  - If `b_rd` is still high, the fill restarts from beat 0.
- Not defined: no counter logic; `err` is tied 0; REQ/WAIT wait indefinitely.

## Test plan
- Zero-wait fill: `b_rd=1`, `b_addr=0x1000`, memory returns 0x11..,0x22..,0x33..,0x44.. -> `m_addr` sequence 0x1000/0x1008/0x1010/0x1018, then `b_dv=1` in cycle 9 with `b_data[255:192]=0x44..` and `b_data[63:0]=0x11..`.
- Stalled grant: hold `m_gnt=0` for 5 cycles on beat 2 -> `m_req` and `m_addr=0x1010` stable throughout; `b_dv` delayed by exactly 5 cycles.
- Flush mid-fill: change `b_addr` to 0x2000 during beat 1 -> fill of 0x1000 completes on the bus, `b_dv` stays 0 in DONE, next fill starts at 0x2000.
- Reset mid-fill: `rst_n=0` during WAIT of beat 1, then a spurious `m_dv` after release -> all outputs 0, state IDLE, `b_data` stays 0.
- Timeout (`IMEM_FILL_TIMEOUT_EN`, TIMEOUT=16): `m_dv` never arrives -> `err` pulses once 16 cycles after WAIT entry, then REQ is reissued for beat 0.
- Back-to-back: two distinct misses queued -> second `m_req` rises exactly 2 cycles after the first `b_dv`.

Source files
------------

// File: rtl/imem_fill_if.sv
// Cache-refill and memory-port signal bundle for imem_fill.
// master = the fill engine, slave = the cache/memory environment around it.
interface imem_fill_if #(
  parameter int LINE_BITS = 256
);
  logic [63:0]          b_addr;
  logic                 b_rd;
  logic [LINE_BITS-1:0] b_data;
  logic                 b_dv;
  logic [63:0]          m_addr;
  logic                 m_req;
  logic                 m_gnt;
  logic [63:0]          m_data;
  logic                 m_dv;
  logic                 err;

  modport master (
    input  b_addr, b_rd, m_gnt, m_data, m_dv,
    output b_data, b_dv, m_addr, m_req, err
  );

  modport slave (
    output b_addr, b_rd, m_gnt, m_data, m_dv,
    input  b_data, b_dv, m_addr, m_req, err
  );
endinterface

// File: rtl/imem_fill.sv
// I-cache line fill: LINE_BITS/64 single-beat reads, 2 cycles/beat at zero wait, one-cycle b_dv; stalls on m_gnt/m_dv.
// Define IMEM_FILL_TIMEOUT_EN to abort a wait after TIMEOUT cycles with an err pulse.
module imem_fill #(
  parameter int LINE_BITS = 256,
  parameter int TIMEOUT   = 255
) (
  input logic         clk,
  input logic         rst_n,
  imem_fill_if.master bus
);
  localparam int NBEATS = LINE_BITS / 64;
  localparam int CW     = $clog2(NBEATS);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [63:0]          r_addr_q;
  logic [LINE_BITS-1:0] r_line;
  logic                 r_m_req;
  logic [63:0]          r_m_addr;
  logic                 w_last;
  logic [63:0]          w_next_addr;

  assign w_last      = (r_cnt == CW'(NBEATS - 1));
  assign w_next_addr = r_addr_q + 64'({r_cnt, 3'b000}) + 64'd8;

`ifdef IMEM_FILL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wcnt;
  logic          r_err;
  logic          w_leave;

  // A wait ends when the handshake it is waiting for arrives.
  assign w_leave = ((r_state == REQ) && bus.m_gnt) || ((r_state == WAIT) && bus.m_dv);
  assign bus.err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign bus.err          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr_q <= '0;
      r_line   <= '0;
      r_m_req  <= 1'b0;
      r_m_addr <= '0;
`ifdef IMEM_FILL_TIMEOUT_EN
      r_wcnt   <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.b_rd) begin
            r_addr_q <= bus.b_addr;
            r_cnt    <= '0;
            r_m_req  <= 1'b1;
            r_m_addr <= bus.b_addr;
            r_state  <= REQ;
          end
        end
        REQ: begin
          if (bus.m_gnt) begin
            r_m_req <= 1'b0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.m_dv) begin
            r_line[{r_cnt, 6'b000000} +: 64] <= bus.m_data;
            if (w_last) begin
              r_state <= DONE;
            end else begin
              r_cnt    <= r_cnt + 1'b1;
              r_m_req  <= 1'b1;
              r_m_addr <= w_next_addr;
              r_state  <= REQ;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
`ifdef IMEM_FILL_TIMEOUT_EN
      // Abort overrides the case above; progress in the same cycle wins over abort.
      r_err <= 1'b0;
      if ((r_state == REQ) || (r_state == WAIT)) begin
        if (w_leave) begin
          r_wcnt <= '0;
        end else if (r_wcnt == TW'(TIMEOUT - 1)) begin
          r_wcnt  <= '0;
          r_err   <= 1'b1;
          r_m_req <= 1'b0;
          r_state <= IDLE;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end else begin
        r_wcnt <= '0;
      end
`endif
    end
  end

  // A stale fill (request dropped or re-addressed) completes silently.
  assign bus.b_dv   = (r_state == DONE) && bus.b_rd && (bus.b_addr == r_addr_q);
  assign bus.b_data = r_line;
  assign bus.m_req  = r_m_req;
  assign bus.m_addr = r_m_addr;
endmodule

// File: tb/tb_imem_fill.sv
// Bench for imem_fill: randomized memory latencies against a line/latency reference model.
`timescale 1ns/1ps
module tb_imem_fill;
  localparam int LB = 256;
  localparam int NB = LB / 64;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  imem_fill_if #(.LINE_BITS(LB)) bus();
  imem_fill #(.LINE_BITS(LB), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: per-beat grant/data delays, optional manual override when mem_on is 0.
  bit          mem_on = 1'b0;
  logic        man_gnt = 1'b0;
  logic        man_dv = 1'b0;
  logic [63:0] man_data = '0;
  int          gq_dly[$];
  int          dq_dly[$];
  logic [63:0] gaddr[$];
  logic [63:0] mem[logic [63:0]];
  int          req_wait = 0;
  int          rsp_wait = 0;
  bit          rsp_pend = 1'b0;
  logic [63:0] rsp_addr = '0;

  function automatic logic [63:0] data_of(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 64'h9E37_79B9_7F4A_7C15) ^ 64'h0123_4567_89AB_CDEF;
  endfunction

  function automatic logic [LB-1:0] exp_line(input logic [63:0] a);
    logic [LB-1:0] l;
    for (int k = 0; k < NB; k++) l[k*64 +: 64] = data_of(a + 64'(8 * k));
    return l;
  endfunction

  always @(negedge clk) begin
    if (!mem_on) begin
      req_wait = 0;
      rsp_pend = 1'b0;
      bus.m_gnt = man_gnt;
      bus.m_dv = man_dv;
      bus.m_data = man_data;
    end else begin
      bus.m_gnt = 1'b0;
      bus.m_dv = 1'b0;
      if (rsp_pend) begin
        if (rsp_wait >= ((dq_dly.size() > 0) ? dq_dly[0] : 0)) begin
          bus.m_dv = 1'b1;
          bus.m_data = data_of(rsp_addr);
          rsp_pend = 1'b0;
          if (dq_dly.size() > 0) void'(dq_dly.pop_front());
        end else begin
          rsp_wait++;
        end
      end else if (bus.m_req) begin
        if (req_wait >= ((gq_dly.size() > 0) ? gq_dly[0] : 0)) begin
          bus.m_gnt = 1'b1;
          gaddr.push_back(bus.m_addr);
          rsp_pend = 1'b1;
          rsp_addr = bus.m_addr;
          rsp_wait = 0;
          req_wait = 0;
          if (gq_dly.size() > 0) void'(gq_dly.pop_front());
        end else begin
          req_wait++;
        end
      end
    end
  end

  task automatic do_reset();
    mem_on = 1'b0;
    man_gnt = 1'b0;
    man_dv = 1'b0;
    bus.b_rd = 1'b0;
    bus.b_addr = '0;
    gq_dly.delete();
    dq_dly.delete();
    gaddr.delete();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issues one miss and waits for b_dv; lat = cycles from miss to b_dv, -1 if none.
  task automatic run_fill(input logic [63:0] a, input int budget, output int lat,
                          output bit err_seen, output logic [LB-1:0] line);
    lat = -1;
    err_seen = 1'b0;
    line = '0;
    @(posedge clk); #1;
    bus.b_addr = a;
    bus.b_rd = 1'b1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (bus.err) err_seen = 1'b1;
      if (bus.b_dv) begin
        lat = n;
        line = bus.b_data;
        break;
      end
    end
    bus.b_rd = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req got=%b exp=0", bus.m_req); end
    checks++; if (bus.m_addr !== 64'd0) begin errors++; $display("FAIL reset_m_addr got=%h exp=0", bus.m_addr); end
    checks++; if (bus.b_dv !== 1'b0) begin errors++; $display("FAIL reset_b_dv got=%b exp=0", bus.b_dv); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", bus.err); end
    checks++; if (bus.b_data !== '0) begin errors++; $display("FAIL reset_b_data got=%h exp=0", bus.b_data); end
  endtask

  task automatic test_zero_wait();
    int lat; bit es; logic [LB-1:0] line;
    do_reset();
    mem[64'h1000] = 64'h1111_1111_1111_1111;
    mem[64'h1008] = 64'h2222_2222_2222_2222;
    mem[64'h1010] = 64'h3333_3333_3333_3333;
    mem[64'h1018] = 64'h4444_4444_4444_4444;
    mem_on = 1'b1;
    run_fill(64'h1000, 100, lat, es, line);
    checks++; if (lat !== 9) begin errors++; $display("FAIL zw_latency got=%0d exp=9", lat); end
    checks++; if (line[255:192] !== 64'h4444_4444_4444_4444) begin errors++; $display("FAIL zw_beat3 got=%h exp=4444444444444444", line[255:192]); end
    checks++; if (line[63:0] !== 64'h1111_1111_1111_1111) begin errors++; $display("FAIL zw_beat0 got=%h exp=1111111111111111", line[63:0]); end
    checks++; if (line !== exp_line(64'h1000)) begin errors++; $display("FAIL zw_line got=%h exp=%h", line, exp_line(64'h1000)); end
    checks++; if (gaddr.size() !== NB) begin errors++; $display("FAIL zw_beats got=%0d exp=%0d", gaddr.size(), NB); end
    for (int k = 0; k < NB && k < gaddr.size(); k++) begin
      checks++;
      if (gaddr[k] !== 64'h1000 + 64'(8 * k)) begin errors++; $display("FAIL zw_m_addr%0d got=%h exp=%h", k, gaddr[k], 64'h1000 + 64'(8 * k)); end
    end
    checks++; if (es !== 1'b0) begin errors++; $display("FAIL zw_err got=%b exp=0", es); end
  endtask

  task automatic test_stall_grant();
    int lat = -1;
    do_reset();
    gq_dly = '{0, 0, 5, 0};
    mem_on = 1'b1;
    @(posedge clk); #1;
    bus.b_addr = 64'h1000;
    bus.b_rd = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n >= 5 && n <= 10) begin
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 64'h1010) begin
          errors++; $display("FAIL stall_hold cyc=%0d got req=%b addr=%h exp req=1 addr=1010", n, bus.m_req, bus.m_addr);
        end
      end
      if (bus.b_dv) begin
        lat = n;
        checks++;
        if (bus.b_data !== exp_line(64'h1000)) begin errors++; $display("FAIL stall_line got=%h exp=%h", bus.b_data, exp_line(64'h1000)); end
        break;
      end
    end
    bus.b_rd = 1'b0;
    checks++; if (lat !== 14) begin errors++; $display("FAIL stall_latency got=%0d exp=14", lat); end
  endtask

  task automatic test_flush();
    int lat = -1; bit early = 1'b0;
    do_reset();
    mem_on = 1'b1;
    @(posedge clk); #1;
    bus.b_addr = 64'h1000;
    bus.b_rd = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (n == 3) bus.b_addr = 64'h2000;
      if (n <= 10 && bus.b_dv) early = 1'b1;
      if (n == 10) begin
        checks++;
        if (bus.b_data !== exp_line(64'h1000)) begin errors++; $display("FAIL flush_hold_line got=%h exp=%h", bus.b_data, exp_line(64'h1000)); end
      end
      if (n == 11) begin
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 64'h2000) begin errors++; $display("FAIL flush_restart got req=%b addr=%h exp req=1 addr=2000", bus.m_req, bus.m_addr); end
      end
      if (n > 10 && bus.b_dv) begin
        lat = n;
        checks++;
        if (bus.b_data !== exp_line(64'h2000)) begin errors++; $display("FAIL flush_line got=%h exp=%h", bus.b_data, exp_line(64'h2000)); end
        break;
      end
    end
    bus.b_rd = 1'b0;
    checks++; if (early !== 1'b0) begin errors++; $display("FAIL flush_stale_b_dv got=1 exp=0"); end
    checks++; if (lat !== 19) begin errors++; $display("FAIL flush_latency got=%0d exp=19", lat); end
    checks++;
    if (gaddr.size() !== 2 * NB) begin
      errors++; $display("FAIL flush_beats got=%0d exp=%0d", gaddr.size(), 2 * NB);
    end else begin
      for (int k = 0; k < 2 * NB; k++) begin
        checks++;
        if (gaddr[k] !== ((k < NB) ? 64'h1000 : 64'h2000) + 64'(8 * (k % NB))) begin
          errors++; $display("FAIL flush_m_addr%0d got=%h", k, gaddr[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midfill();
    do_reset();
    mem_on = 1'b1;
    @(posedge clk); #1;
    bus.b_addr = 64'h3000;
    bus.b_rd = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    mem_on = 1'b0;
    bus.b_rd = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    man_dv = 1'b1;
    man_data = {$urandom, $urandom};
    @(posedge clk); #1;
    man_dv = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.m_req !== 1'b0 || bus.m_addr !== 64'd0 || bus.b_dv !== 1'b0 || bus.err !== 1'b0) begin
        errors++; $display("FAIL rstmid_outputs got req=%b addr=%h dv=%b err=%b exp all 0", bus.m_req, bus.m_addr, bus.b_dv, bus.err);
      end
    end
    checks++; if (bus.b_data !== '0) begin errors++; $display("FAIL rstmid_b_data got=%h exp=0", bus.b_data); end
  endtask

  task automatic test_back_to_back();
    int lat1 = -1; int lat2 = -1;
    do_reset();
    mem_on = 1'b1;
    @(posedge clk); #1;
    bus.b_addr = 64'h4000;
    bus.b_rd = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.b_dv) begin lat1 = n; break; end
    end
    checks++; if (lat1 !== 9) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=9", lat1); end
    @(posedge clk); #1;
    bus.b_addr = 64'h5040;
    checks++; if (bus.m_req !== 1'b0) begin errors++; $display("FAIL b2b_req_early got=%b exp=0", bus.m_req); end
    @(posedge clk); #1;
    checks++;
    if (bus.m_req !== 1'b1 || bus.m_addr !== 64'h5040) begin errors++; $display("FAIL b2b_second_req got req=%b addr=%h exp req=1 addr=5040", bus.m_req, bus.m_addr); end
    for (int n = 2; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.b_dv) begin
        lat2 = n;
        checks++;
        if (bus.b_data !== exp_line(64'h5040)) begin errors++; $display("FAIL b2b_line got=%h exp=%h", bus.b_data, exp_line(64'h5040)); end
        break;
      end
    end
    bus.b_rd = 1'b0;
    checks++; if (lat2 !== 9) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=9", lat2); end
  endtask

  task automatic test_random();
    int lat; bit es; logic [LB-1:0] line; logic [63:0] a; int exp_lat; int g; int d; bit ok;
    do_reset();
    mem_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom};
      a[4:0] = 5'd0;
      exp_lat = 1;
      for (int k = 0; k < NB; k++) begin
        g = $urandom_range(0, 3);
        d = $urandom_range(0, 3);
        gq_dly.push_back(g);
        dq_dly.push_back(d);
        exp_lat += g + d + 2;
      end
      gaddr.delete();
      run_fill(a, 200, lat, es, line);
      checks++; if (lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, exp_lat); end
      checks++; if (line !== exp_line(a)) begin errors++; $display("FAIL rnd%0d_line got=%h exp=%h", i, line, exp_line(a)); end
      ok = (gaddr.size() == NB);
      for (int k = 0; k < NB && k < gaddr.size(); k++) if (gaddr[k] !== a + 64'(8 * k)) ok = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL rnd%0d_addr_seq got %0d beats, first=%h exp base=%h", i, gaddr.size(), (gaddr.size() > 0) ? gaddr[0] : 64'd0, a); end
      checks++; if (es !== 1'b0) begin errors++; $display("FAIL rnd%0d_err got=1 exp=0", i); end
    end
  endtask

`ifdef IMEM_FILL_TIMEOUT_EN
  task automatic test_timeout();
    int pulses = 0; int err_cyc = -1;
    do_reset();
    man_gnt = 1'b1;
    @(posedge clk); #1;
    bus.b_addr = 64'h6000;
    bus.b_rd = 1'b1;
    for (int n = 1; n <= 19; n++) begin
      @(posedge clk); #1;
      if (n == 2) man_gnt = 1'b0;
      if (bus.err) begin pulses++; err_cyc = n; end
      if (n == 19) begin
        checks++;
        if (bus.m_req !== 1'b1 || bus.m_addr !== 64'h6000) begin errors++; $display("FAIL to_reissue got req=%b addr=%h exp req=1 addr=6000", bus.m_req, bus.m_addr); end
      end
    end
    bus.b_rd = 1'b0;
    checks++; if (pulses !== 1) begin errors++; $display("FAIL to_pulses got=%0d exp=1", pulses); end
    checks++; if (err_cyc !== 18) begin errors++; $display("FAIL to_err_cycle got=%0d exp=18", err_cyc); end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_grant();
    test_flush();
    test_reset_midfill();
    test_back_to_back();
    test_random();
`ifdef IMEM_FILL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
